timed_pattern_gen: RTL and testbench
====================================

// Module: timed_pattern_gen
// PURPOSE
//   Synthesizable, programmable timed waveform sequencer: plays a table of (value, delay) steps onto a
//   WIDTH-bit output, each value applied a programmed number of clk cycles after the previous one.
//   Replaces hand-written #delay stimulus blocks; sits between a config master and the logic it drives.
// PARAMETERS
//   WIDTH     4   output/step value width (bits)
//   DEPTH     8   number of step-table entries (power of 2, >=2)
//   DLY_W     8   delay field width; per-step delay range 1..2**DLY_W-1 cycles
//   INIT_VAL  0   value driven on out after reset
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   wr_en      in   1               step-table write strobe
//   wr_addr    in   $clog2(DEPTH)   table index to write
//   wr_value   in   WIDTH           step value
//   wr_delay   in   DLY_W           step delay in cycles (0 treated as 1)
//   num_steps  in   $clog2(DEPTH)+1 steps to play (1..DEPTH), sampled on start
//   start      in   1               begin playback (IDLE only)
//   stop       in   1               abort playback
//   out        out  WIDTH           generated waveform
//   busy       out  1               high while state==RUN
//   step_idx   out  $clog2(DEPTH)   index of step currently being timed
//   done       out  1               one-cycle pulse after last step applied (non-loop)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state=IDLE, out=INIT_VAL, busy=0, done=0, step_idx=0, counter=0;
//     table contents NOT cleared. rst mid-playback aborts immediately, no done.
//   - FSM: IDLE -> RUN on start && num_steps in 1..DEPTH (else start ignored, stay IDLE).
//     RUN -> IDLE on stop, or after last step applied when not looping.
//   - Timing: start accepted at edge T loads counter=max(delay[0],1); counter decrements each cycle;
//     step i value appears on out at edge T + sum(delay[0..i]). No value changes before its delay.
//   - On applying step i: out<=value[i]; if i<num_steps-1: step_idx<=i+1, counter<=delay[i+1].
//     Last step: done=1 for exactly one cycle (same edge busy falls), out holds last value.
//   - Writes: accepted in IDLE only; wr_en during RUN ignored. Write and start same cycle: write lands,
//     start uses table contents prior to that write.
//   - start while busy: ignored. stop in IDLE: no effect.
//   - stop coinciding with a step's due edge: stop wins, that step NOT applied, out holds, no done.
//   - counter width DLY_W; no wrap: reload only on step application.
// CONFIGURATION
//   PATGEN_LOOP_EN defined: extra input port loop (1 bit, sampled on start). If loop=1, after last step
//     step_idx wraps to 0, counter<=delay[0], playback continues until stop/rst; done never pulses.
//   PATGEN_LOOP_EN undefined: no loop port; playback always one-shot as above.
// STRUCTURE
//   Package patgen_pkg: state enum {IDLE, RUN}; function clamp_dly (0->1).
//   Sub-module patgen_step_ram: DEPTH x (WIDTH+DLY_W) register file, 1 sync write, 1 async read.
//   Top holds FSM, down-counter, step index, output register.
// TESTING
//   1) WIDTH=4; table {(6,5),(5,6),(1,2),(0,9),(5,1)}, num_steps=5, start @cycle 0 ->
//      out=6@5, 5@11, 1@13, 0@22, 5@23; done pulse @23; busy 1 for cycles 1..22.
//   2) stop asserted @cycle 12 in scenario 1 -> out stays 5, busy=0 @12, no done; restart replays from step 0.
//   3) delay[0]=0, value 0xA, num_steps=1 -> out=0xA one cycle after start, done same edge.
//   4) wr_en to addr 0 during RUN -> table unchanged (replay shows original value); start while busy ignored.
//   5) rst asserted mid-playback -> next edge out=INIT_VAL, busy=0, done=0; table retained.
//   6) PATGEN_LOOP_EN, loop=1, table {(3,2),(7,3)} -> out 3@2, 7@5, 3@7, 7@10...; done never 1.

Source files
------------

// File: rtl/patgen_pkg.sv
// Shared types and helpers for the timed pattern generator.
package patgen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A programmed delay of zero is treated as a single cycle.
  function automatic logic [31:0] clamp_dly(input logic [31:0] d);
    return (d == '0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/patgen_step_ram.sv
// Step table: DEPTH x DW register file, one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset.
module patgen_step_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/timed_pattern_gen.sv
// Programmable timed waveform sequencer: plays (value, delay) steps from a table onto out.
// Define PATGEN_LOOP_EN to add the loop input for continuous playback.
module timed_pattern_gen
  import patgen_pkg::*;
#(
  parameter int unsigned       WIDTH    = 4,
  parameter int unsigned       DEPTH    = 8,
  parameter int unsigned       DLY_W    = 8,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_value,
  input  logic [DLY_W-1:0]           wr_delay,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       start,
  input  logic                       stop,
`ifdef PATGEN_LOOP_EN
  input  logic                       loop,
`endif
  output logic [WIDTH-1:0]           out,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned EW = WIDTH + DLY_W;

  state_t            state;
  logic [DLY_W-1:0]  counter;
  logic [AW-1:0]     last_idx;
  logic [WIDTH-1:0]  cur_val;
  logic              loop_q;
  logic              loop_in;

  logic              pend_v;
  logic [AW-1:0]     pend_addr;
  logic [EW-1:0]     pend_data;

  logic              start_ok;
  logic              due;
  logic              is_last;
  logic              finishing;
  logic              to_idle;
  logic [AW-1:0]     next_idx;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  logic [WIDTH-1:0]  rd_value;
  logic [DLY_W-1:0]  rd_delay;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [EW-1:0]     ram_wdata;

`ifdef PATGEN_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = 1'b0;
`endif

  assign start_ok  = (state == IDLE) && start &&
                     (num_steps != '0) && (num_steps <= NW'(DEPTH));
  assign due       = (state == RUN) && (counter == DLY_W'(1));
  assign is_last   = (step_idx == last_idx);
  assign finishing = due && !stop && is_last && !loop_q;
  assign to_idle   = rst || ((state == RUN) && (stop || finishing));
  assign next_idx  = is_last ? '0 : step_idx + AW'(1);

  // The read port always looks one step ahead: at the due edge of step i we
  // need value/delay of step i+1, while step i's value is already in cur_val.
  assign rd_addr  = (state == RUN) ? next_idx : '0;
  assign rd_value = rd_data[EW-1:DLY_W];
  assign rd_delay = rd_data[DLY_W-1:0];

  // A write coinciding with an accepted start is held back and committed when
  // playback ends, so the running sequence only ever sees the pre-write table.
  assign ram_we    = ((state == IDLE) && wr_en && !start_ok) || (pend_v && to_idle);
  assign ram_waddr = pend_v ? pend_addr : wr_addr;
  assign ram_wdata = pend_v ? pend_data : {wr_value, wr_delay};

  patgen_step_ram #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_step_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= INIT_VAL;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      counter   <= '0;
      last_idx  <= '0;
      cur_val   <= '0;
      loop_q    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= RUN;
            busy      <= 1'b1;
            step_idx  <= '0;
            last_idx  <= AW'(num_steps - NW'(1));
            counter   <= DLY_W'(clamp_dly(32'(rd_delay)));
            cur_val   <= rd_value;
            loop_q    <= loop_in;
            pend_v    <= wr_en;
            pend_addr <= wr_addr;
            pend_data <= {wr_value, wr_delay};
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            pend_v  <= 1'b0;
          end else if (due) begin
            out <= cur_val;
            if (is_last && !loop_q) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              counter <= '0;
              pend_v  <= 1'b0;
            end else begin
              step_idx <= next_idx;
              counter  <= DLY_W'(clamp_dly(32'(rd_delay)));
              cur_val  <= rd_value;
            end
          end else begin
            counter <= counter - DLY_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timed_pattern_gen.sv
// Directed self-checking bench for timed_pattern_gen; expected waveforms are hand-computed step times.
module tb_timed_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_value;
  logic [7:0] wr_delay;
  logic [3:0] num_steps;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] out;
  logic       busy;
  logic [2:0] step_idx;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  // absolute edge of each step (start accepted at edge 0) and its value
  int tm [8];
  int vv [8];

  always #5 clk = ~clk;

  timed_pattern_gen #(
    .WIDTH    (4),
    .DEPTH    (8),
    .DLY_W    (8),
    .INIT_VAL (4'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_value  (wr_value),
    .wr_delay  (wr_delay),
    .num_steps (num_steps),
    .start     (start),
    .stop      (stop),
`ifdef PATGEN_LOOP_EN
    .loop      (loop),
`endif
    .out       (out),
    .busy      (busy),
    .step_idx  (step_idx),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] v, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_value = v; wr_delay = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_main_table();
    tm[0] = 5;  vv[0] = 6;
    tm[1] = 11; vv[1] = 5;
    tm[2] = 13; vv[2] = 1;
    tm[3] = 22; vv[3] = 0;
    tm[4] = 23; vv[4] = 5;
  endtask

  // Starts playback then checks every cycle against tm/vv. stop_at/rst_at/meddle_at = 0 disables.
  // meddle_at drives a write to entry 0 plus a second start while running; wws writes entry 0
  // (0xF, 3) in the very cycle start is accepted.
  task automatic play(input int n, input int stop_at, input int rst_at, input int meddle_at,
                      input bit wws, input logic [3:0] prev_out, input int cycles, input string nm);
    logic [3:0] e_out;
    bit halted;
    int applied;
    e_out = prev_out; halted = 0; applied = 0;
    num_steps = 4'(n);
    start = 1'b1;
    if (wws) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_value = 4'hF; wr_delay = 8'd3;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      stop = (k == stop_at);
      rst  = (k == rst_at);
      if (k == meddle_at) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_value = 4'hF; wr_delay = 8'd1; start = 1'b1;
      end
      tick();
      stop = 1'b0; rst = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (k == rst_at) begin
        halted = 1; e_out = 4'h0;
      end else if (k == stop_at) begin
        halted = 1;
      end
      if (!halted && applied < n && k == tm[applied]) begin
        e_out = 4'(vv[applied]);
        applied++;
      end
      check($sformatf("%s out@%0d", nm, k), 32'(out), 32'(e_out));
      if (k >= 1 && k <= 25 || k == cycles) begin
        check($sformatf("%s busy@%0d", nm, k), 32'(busy), 32'(!halted && applied < n));
        check($sformatf("%s done@%0d", nm, k), 32'(done),
              32'(!halted && applied == n && k == tm[n-1]));
      end
      if (!halted && applied < n)
        check($sformatf("%s idx@%0d", nm, k), 32'(step_idx), 32'(applied));
      if (k == rst_at)
        check($sformatf("%s idx_rst@%0d", nm, k), 32'(step_idx), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_value = '0; wr_delay = '0;
    num_steps = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    tick(); tick();
    check("rst out", 32'(out), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst idx", 32'(step_idx), 32'h0);
    rst = 1'b0;

    wr(3'd0, 4'd6, 8'd5);
    wr(3'd1, 4'd5, 8'd6);
    wr(3'd2, 4'd1, 8'd2);
    wr(3'd3, 4'd0, 8'd9);
    wr(3'd4, 4'd5, 8'd1);
    set_main_table();

    // num_steps outside 1..DEPTH must not start playback
    num_steps = 4'd0; start = 1'b1; tick(); start = 1'b0; tick();
    check("ns0 busy", 32'(busy), 32'h0);
    num_steps = 4'd9; start = 1'b1; tick(); start = 1'b0; tick();
    check("ns9 busy", 32'(busy), 32'h0);
    check("ns9 out", 32'(out), 32'h0);

    play(5, 0, 0, 0, 0, 4'h0, 26, "s1");
    play(5, 12, 0, 0, 0, 4'h5, 14, "s2stop");
    check("s2 done_after", 32'(done), 32'h0);
    play(5, 0, 0, 0, 0, 4'h5, 26, "s2replay");

    play(5, 0, 0, 3, 0, 4'h5, 26, "s4run");
    play(5, 0, 0, 0, 0, 4'h5, 26, "s4replay");

    // write landing with start: this run uses the old entry 0, the next uses (0xF, 3)
    play(5, 0, 0, 0, 1, 4'h5, 26, "wws_old");
    tm[0] = 3;  vv[0] = 15;
    tm[1] = 9;  tm[2] = 11; tm[3] = 20; tm[4] = 21;
    play(5, 0, 0, 0, 0, 4'h5, 24, "wws_new");
    wr(3'd0, 4'd6, 8'd5);
    set_main_table();

    play(5, 0, 8, 0, 0, 4'h5, 10, "s5rst");
    play(5, 0, 0, 0, 0, 4'h0, 26, "s5replay");

    wr(3'd0, 4'hA, 8'd0);
    tm[0] = 1; vv[0] = 10;
    play(1, 0, 0, 0, 0, 4'h5, 3, "s3");

`ifdef PATGEN_LOOP_EN
    begin
      int exp_t [5];
      int exp_v [5];
      logic [3:0] e;
      int j;
      exp_t = '{2, 5, 7, 10, 12};
      exp_v = '{3, 7, 3, 7, 3};
      wr(3'd0, 4'd3, 8'd2);
      wr(3'd1, 4'd7, 8'd3);
      loop = 1'b1; num_steps = 4'd2; start = 1'b1;
      tick();
      start = 1'b0; loop = 1'b0;
      e = 4'hA; j = 0;
      for (int k = 1; k <= 13; k++) begin
        tick();
        if (j < 5 && k == exp_t[j]) begin
          e = 4'(exp_v[j]);
          j++;
        end
        check($sformatf("loop out@%0d", k), 32'(out), 32'(e));
        check($sformatf("loop done@%0d", k), 32'(done), 32'h0);
        check($sformatf("loop busy@%0d", k), 32'(busy), 32'h1);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      check("loop stop busy", 32'(busy), 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
